// File: rtl/tv80_mdu.sv
// Iterative multiply/divide unit with Z80-style result flags.
// One shift-add or restoring shift-subtract step per cycle on operand magnitudes; signs are fixed up at the end.
module tv80_mdu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q_hi,
    output logic [WIDTH-1:0] q_lo,
    output logic [7:0]       f_out
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         op_reg;
    logic               sign_a_reg, sign_b_reg;
    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH:0]     hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-1:0]   q_hi_reg, q_lo_reg;
    logic [7:0]         f_reg;

    logic               a_neg, b_neg, div_by_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, mul_acc, div_rem_sh;
    logic [WIDTH+1:0]   div_diff;
    logic [WIDTH:0]     step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               res_c, res_div, quo_neg, rem_neg, y_bit;
    logic [7:0]         f_next;

    assign busy  = (state_reg != IDLE);
    assign done  = (state_reg == DONE);
    assign q_hi  = q_hi_reg;
    assign q_lo  = q_lo_reg;
    assign f_out = f_reg;

    // Signed ops work on magnitudes; -MIN wraps to the correct unsigned magnitude.
    always_comb begin
        a_neg       = op[0] & a[WIDTH-1];
        b_neg       = op[0] & b[WIDTH-1];
        a_mag       = a_neg ? -a : a;
        b_mag       = b_neg ? -b : b;
        div_by_zero = op[1] & (b == '0);
    end

    always_comb begin
        mul_sum    = hi_reg + {1'b0, mcand_reg};
        mul_acc    = lo_reg[0] ? mul_sum : hi_reg;
        div_rem_sh = {hi_reg[WIDTH-1:0], lo_reg[WIDTH-1]};
        div_diff   = {1'b0, div_rem_sh} - {2'b00, mcand_reg};
        step_hi    = {1'b0, mul_acc[WIDTH:1]};
        step_lo    = {mul_acc[0], lo_reg[WIDTH-1:1]};
        if (op_reg[1]) begin
            if (!div_diff[WIDTH+1]) begin
                step_hi = div_diff[WIDTH:0];
                step_lo = {lo_reg[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_rem_sh;
                step_lo = {lo_reg[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Final result: divide-by-zero shortcut while still in IDLE, otherwise sign-corrected run result.
    always_comb begin
        quo_neg  = op_reg[0] & (sign_a_reg ^ sign_b_reg);
        rem_neg  = op_reg[0] & sign_a_reg;
        prod_mag = {hi_reg[WIDTH-1:0], lo_reg};
        prod     = quo_neg ? -prod_mag : prod_mag;
        res_hi   = prod[2*WIDTH-1:WIDTH];
        res_lo   = prod[WIDTH-1:0];
        res_c    = 1'b0;
        res_div  = 1'b0;
        if (state_reg == IDLE) begin
            res_hi  = a;
            res_lo  = '1;
            res_c   = 1'b1;
            res_div = 1'b1;
        end else if (op_reg[1]) begin
            res_lo  = quo_neg ? -lo_reg : lo_reg;
            res_hi  = rem_neg ? -hi_reg[WIDTH-1:0] : hi_reg[WIDTH-1:0];
            res_c   = op_reg[0] & ~quo_neg & lo_reg[WIDTH-1];
            res_div = 1'b1;
        end else if (op_reg[0]) begin
            res_c = (res_hi != {WIDTH{res_lo[WIDTH-1]}});
        end else begin
            res_c = |res_hi;
        end
    end

    generate
        if (WIDTH >= 6) begin : g_y
            assign y_bit = res_lo[5];
        end else begin : g_no_y
            assign y_bit = 1'b0;
        end
    endgenerate

    always_comb begin
        f_next    = 8'h00;
        f_next[7] = res_div ? res_lo[WIDTH-1] : res_hi[WIDTH-1];
        f_next[6] = res_div ? ~|res_lo : ~|{res_hi, res_lo};
        f_next[5] = y_bit;
        f_next[3] = res_lo[3];
        f_next[2] = res_c;
        f_next[0] = res_c;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = div_by_zero ? DONE : RUN;
            RUN:  if (cnt_reg == CW'(WIDTH - 1)) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            mcand_reg  <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            cnt_reg    <= '0;
            q_hi_reg   <= '0;
            q_lo_reg   <= '0;
            f_reg      <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (start) begin
                    op_reg     <= op;
                    sign_a_reg <= a_neg;
                    sign_b_reg <= b_neg;
                    cnt_reg    <= '0;
                    hi_reg     <= '0;
                    lo_reg     <= op[1] ? a_mag : b_mag;
                    mcand_reg  <= op[1] ? b_mag : a_mag;
                    if (div_by_zero) begin
                        q_hi_reg <= res_hi;
                        q_lo_reg <= res_lo;
                        f_reg    <= f_next;
                    end
                end
                RUN: begin
                    hi_reg  <= step_hi;
                    lo_reg  <= step_lo;
                    cnt_reg <= cnt_reg + 1'b1;
                end
                FIX: begin
                    q_hi_reg <= res_hi;
                    q_lo_reg <= res_lo;
                    f_reg    <= f_next;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tv80_mdu.sv
// Directed-vector bench for tv80_mdu at WIDTH=8 with hand-computed products, quotients and flags.
module tb_tv80_mdu;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic       busy, done;
    logic [7:0] q_hi, q_lo, f_out;
    int         n_vec = 0;
    int         n_err = 0;

    tv80_mdu #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .q_hi(q_hi), .q_lo(q_lo), .f_out(f_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~o; a = ~x; b = ~y;
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                         input int lat, input logic [7:0] eh, input logic [7:0] el, input logic [7:0] ef);
        int k;
        launch(o, x, y);
        k = 0;
        while (!done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1 && lat > 1) check({tag, " busy"}, 32'(busy), 32'd1);
        end
        check({tag, " latency"}, k, lat);
        check({tag, " q_hi"}, 32'(q_hi), 32'(eh));
        check({tag, " q_lo"}, 32'(q_lo), 32'(el));
        check({tag, " f_out"}, 32'(f_out), 32'(ef));
        @(posedge clk);
        #1;
        check({tag, " done pulse ends"}, 32'({done, busy}), 32'd0);
        check({tag, " q_lo held"}, 32'(q_lo), 32'(el));
    endtask

    initial begin
        int nd;
        int k;
        #2;
        check("reset outputs", {busy, done, q_hi, q_lo, f_out}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        do_op("MULU FFxFF", 2'b00, 8'hFF, 8'hFF, 9, 8'hFE, 8'h01, 8'h85);
        do_op("MULS FEx03", 2'b01, 8'hFE, 8'h03, 9, 8'hFF, 8'hFA, 8'hA8);
        do_op("MULU 00x37", 2'b00, 8'h00, 8'h37, 9, 8'h00, 8'h00, 8'h40);
        do_op("DIVU 64/07", 2'b10, 8'h64, 8'h07, 9, 8'h02, 8'h0E, 8'h08);
        do_op("DIVS 9C/07", 2'b11, 8'h9C, 8'h07, 9, 8'hFE, 8'hF2, 8'hA0);
        do_op("DIVU 55/00", 2'b10, 8'h55, 8'h00, 0, 8'h55, 8'hFF, 8'hAD);
        do_op("DIVS 80/FF", 2'b11, 8'h80, 8'hFF, 9, 8'h00, 8'h80, 8'h85);

        // Restart attempt mid-operation must be ignored.
        launch(2'b00, 8'h12, 8'h34);
        repeat (2) @(posedge clk);
        @(negedge clk);
        op = 2'b10; a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nd = 0;
        k = 3;
        while (nd == 0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (done) nd++;
        end
        check("restart latency", k, 9);
        check("restart q_hi", 32'(q_hi), 32'h03);
        check("restart q_lo", 32'(q_lo), 32'hA8);
        check("restart f_out", 32'(f_out), 32'h2D);
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("restart done count", nd, 1);

        // Reset mid-divide clears everything immediately.
        launch(2'b10, 8'h64, 8'h07);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("reset mid-op", {busy, done, q_hi, q_lo, f_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check("aborted done count", nd, 0);
        do_op("MULU 02x03", 2'b00, 8'h02, 8'h03, 9, 8'h00, 8'h06, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tv80_mdu.md
TV80_MDU -- requirements
Module: tv80_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width; legal values are 4..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a request sampled only while idle.
REQ-005 SHALL have port op, input, 2, selecting 00 MULU, 01 MULS, 10 DIVU, 11 DIVS.
REQ-006 SHALL have ports a and b, each input, WIDTH: a is multiplicand/dividend, b is multiplier/divisor.
REQ-007 SHALL have port busy, output, 1, high in every state other than IDLE.
REQ-008 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-009 SHALL have ports q_hi and q_lo, each output, WIDTH: the product high/low half, or remainder/quotient for divides.
REQ-010 SHALL have port f_out, output, 8, Z80 flag layout: S=7, Z=6, Y=5, H=4, X=3, P/V=2, N=1, C=0.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN, FIX and DONE, all updated on clk rising edge.
REQ-012 SHALL, at edge E0 where start=1 in IDLE, capture op, a and b, clear the iteration counter and enter RUN; later changes to op, a and b SHALL have no effect.
REQ-013 SHALL ignore start while busy=1, with no queueing and no restart.
REQ-014 SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per RUN cycle, for exactly WIDTH steps on magnitudes.
REQ-015 SHALL move RUN to FIX at edge E0+WIDTH; at E0+WIDTH+1, FIX SHALL apply sign correction, register q_hi, q_lo and f_out, and enter DONE.
REQ-016 SHALL keep done=1 for exactly the one cycle following E0+WIDTH+1, then return to IDLE at the next edge.
REQ-017 SHALL hold q_hi, q_lo and f_out stable from the DONE entry until the next completion.
REQ-018 SHALL form MULU as the unsigned 2*WIDTH-bit product {q_hi,q_lo}, with C=1 iff q_hi is nonzero.
REQ-019 SHALL form MULS as the two's-complement product {q_hi,q_lo}, with C=1 iff q_hi is not the sign extension of q_lo[WIDTH-1].
REQ-020 SHALL form DIVU as q_lo=quotient and q_hi=remainder.
REQ-021 SHALL form DIVS with the quotient truncated toward zero and the remainder taking the dividend's sign.
REQ-022 SHALL, when b=0 on a divide, go IDLE->DONE directly at E0 (done in the cycle after E0): q_lo all ones, q_hi=a, C=1, with no RUN cycles.
REQ-023 SHALL, on DIVS of the most-negative value by -1, produce q_lo=2^(WIDTH-1), q_hi=0 and C=1 after the full WIDTH+2 latency.
REQ-024 SHALL, for multiplies, set S=q_hi[WIDTH-1] and Z=1 iff {q_hi,q_lo}==0.
REQ-025 SHALL, for divides, set S=q_lo[WIDTH-1] and Z=1 iff q_lo==0.
REQ-026 SHALL set, for all ops: H=0, N=0, P/V=C, X=q_lo[3], Y=q_lo[5]; when WIDTH<6, missing bits read 0.

Reset
REQ-027 SHALL, while reset=1, immediately force the IDLE state, busy=0, done=0, q_hi=0, q_lo=0, f_out=0 and counter=0, independent of clk.
REQ-028 SHALL abort any operation in progress on reset, produce no done pulse for it, and accept start from the first edge after reset is released.

Verification (WIDTH=8, E0 = start edge)
REQ-029 SHALL verify: MULU a=0xFF, b=0xFF -> done after E0+9, q_hi=0xFE, q_lo=0x01, f_out C=1, S=1, Z=0, P/V=1.
REQ-030 SHALL verify: MULS a=0xFE, b=0x03 -> q_hi=0xFF, q_lo=0xFA, C=0, S=1; then MULU 0x00*0x37 -> Z=1, C=0.
REQ-031 SHALL verify: DIVU 0x64/0x07 -> q_lo=0x0E, q_hi=0x02, C=0; DIVS 0x9C/0x07 -> q_lo=0xF2, q_hi=0xFE, S=1.
REQ-032 SHALL verify: DIVU 0x55/0x00 -> done in the cycle after E0, q_lo=0xFF, q_hi=0x55, C=1; DIVS 0x80/0xFF -> q_lo=0x80, q_hi=0x00, C=1 after E0+9.
REQ-033 SHALL verify: start pulsed at E0+3 during a MULU with changed a and b -> ignored; one done only, with the result of the original operands.
REQ-034 SHALL verify: reset asserted at E0+4 mid-DIVU -> busy=0, outputs=0 at once, no done; a new MULU 0x02*0x03 then yields q_lo=0x06.
